// File: rtl/bright_pkg.sv
// Shared brightness definitions: luma weights, statistics FSM encoding,
// step codes (also used by the brightness adjust block) and auto-step thresholds.
package bright_pkg;

  localparam int unsigned LUMA_KR = 77;
  localparam int unsigned LUMA_KG = 150;
  localparam int unsigned LUMA_KB = 29;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DIV   = 2'd2,
    ST_DONE  = 2'd3
  } stat_state_e;

  typedef logic [2:0] step_t;

  // 0 holds, 1..4 darken progressively, 5..7 brighten progressively
  localparam step_t STEP_HOLD = 3'd0;
  localparam step_t STEP_DN1  = 3'd1;
  localparam step_t STEP_DN2  = 3'd2;
  localparam step_t STEP_DN3  = 3'd3;
  localparam step_t STEP_DN4  = 3'd4;
  localparam step_t STEP_UP1  = 3'd5;
  localparam step_t STEP_UP2  = 3'd6;
  localparam step_t STEP_UP3  = 3'd7;

  localparam logic [7:0] THR_UP2  = 8'd80;
  localparam logic [7:0] THR_UP1  = 8'd100;
  localparam logic [7:0] THR_HOLD = 8'd120;
  localparam logic [7:0] THR_DN1  = 8'd140;
  localparam logic [7:0] THR_DN2  = 8'd160;
  localparam logic [7:0] THR_DN3  = 8'd180;
  localparam logic [7:0] THR_DN4  = 8'd200;

  typedef struct packed {
    logic        vld;
    logic [15:0] rg;
    logic [12:0] b;
  } luma_p1_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] y;
  } luma_p2_t;

  function automatic step_t step_of_mean(input logic [7:0] m);
    step_t s;
    if (m < THR_UP2)       s = STEP_UP3;
    else if (m < THR_UP1)  s = STEP_UP2;
    else if (m < THR_HOLD) s = STEP_UP1;
    else if (m < THR_DN1)  s = STEP_HOLD;
    else if (m < THR_DN2)  s = STEP_DN1;
    else if (m < THR_DN3)  s = STEP_DN2;
    else if (m < THR_DN4)  s = STEP_DN3;
    else                   s = STEP_DN4;
    return s;
  endfunction

endpackage

// File: rtl/luma_div.sv
// Restoring divider, one quotient bit per cycle; done_i/quo_o valid on the last of SUM_W cycles.
// start_i loads operands (restarting any divide in flight); a zero divisor yields a zero quotient.
module luma_div #(
  parameter int unsigned SUM_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dvd_i,
  input  logic [SUM_W-1:0] dvs_i,
  output logic             done_o,
  output logic [SUM_W-1:0] quo_o
);

  localparam int unsigned CNT_BITS = $clog2(SUM_W + 1);

  logic                run_q, run_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]    rem_q, rem_d;
  logic [SUM_W-1:0]    quo_q, quo_d;
  logic [SUM_W-1:0]    dvs_q, dvs_d;
  logic [SUM_W:0]      rem_sh;
  logic [SUM_W:0]      diff;

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    done_o = 1'b0;
    rem_sh = {rem_q, quo_q[SUM_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = CNT_BITS'(SUM_W);
      rem_d = '0;
      quo_d = dvd_i;
      dvs_d = dvs_i;
    end else if (run_q) begin
      // borrow clear means the divisor fits: keep the difference, emit a 1
      if (!diff[SUM_W]) begin
        rem_d = diff[SUM_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[SUM_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_BITS'(1);
      if (cnt_q == CNT_BITS'(1)) begin
        run_d  = 1'b0;
        done_o = 1'b1;
      end
    end
    quo_o = (dvs_q == '0) ? '0 : quo_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/bright_stat.sv
// Per-frame mean luma of RGB565 video; report pulses SUM_W+3 cycles after frame end; no backpressure.
// Define BRIGHT_STAT_AUTO_EN to register a brightness step code from each new mean, else step_o is 0.
module bright_stat
  import bright_pkg::*;
#(
  parameter int unsigned CNT_W  = 20,
  parameter bit          VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rgb_data_i,
  input  logic        data_en_i,
  input  logic        vs_in,
  input  logic        de_in,
  output logic [7:0]  mean_o,
  output logic        mean_valid_o,
  output logic        busy_o,
  output logic [2:0]  step_o
);

  localparam int unsigned SUM_W = CNT_W + 8;

  luma_p1_t          p1_q, p1_d;
  luma_p2_t          p2_q, p2_d;
  logic [7:0]        r8, g8, b8;
  logic [15:0]       y_sum;

  logic [SUM_W-1:0]  sum_q, sum_d, sum_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nxt;
  logic [SUM_W:0]    sum_add;
  logic [CNT_W:0]    cnt_add;

  stat_state_e       st_q, st_d;
  logic              drain_q, drain_d;
  logic              vs_q, vs_d;
  logic              frame_end;
  logic [7:0]        mean_q, mean_d;
  logic [7:0]        mean_new;
  logic              mean_ld;

  logic              div_start;
  logic              div_done;
  logic [SUM_W-1:0]  div_quo;

  always_comb begin
    r8    = {rgb_data_i[15:11], 3'b000};
    g8    = {rgb_data_i[10:5],  2'b00};
    b8    = {rgb_data_i[4:0],   3'b000};
    p1_d.vld = de_in & data_en_i;
    p1_d.rg  = 16'(LUMA_KR * r8 + LUMA_KG * g8);
    p1_d.b   = 13'(LUMA_KB * b8);
    y_sum    = p1_q.rg + {3'b000, p1_q.b};
    p2_d.vld = p1_q.vld;
    p2_d.y   = y_sum[15:8];
  end

  // Saturating accumulate of whatever leaves the luma pipe this cycle
  always_comb begin
    sum_add = {1'b0, sum_q} + {{(SUM_W-7){1'b0}}, p2_q.y};
    cnt_add = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    sum_nxt = sum_q;
    cnt_nxt = cnt_q;
    if (p2_q.vld) begin
      sum_nxt = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
      cnt_nxt = cnt_add[CNT_W] ? '1 : cnt_add[CNT_W-1:0];
    end
  end

  always_comb begin
    vs_d      = vs_in;
    frame_end = (vs_in == VS_POL) && (vs_q != VS_POL);
    st_d      = st_q;
    drain_d   = 1'b0;
    div_start = 1'b0;
    sum_d     = sum_nxt;
    cnt_d     = cnt_nxt;
    mean_ld   = 1'b0;
    mean_new  = (|div_quo[SUM_W-1:8]) ? 8'hFF : div_quo[7:0];
    case (st_q)
      ST_ACCUM: if (frame_end) st_d = ST_DRAIN;
      ST_DRAIN: begin
        drain_d = 1'b1;
        // second drain cycle: the last pixel of the frame has reached sum_nxt
        if (drain_q) begin
          drain_d   = 1'b0;
          div_start = 1'b1;
          sum_d     = '0;
          cnt_d     = '0;
          st_d      = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          mean_ld = 1'b1;
          st_d    = ST_DONE;
        end
      end
      ST_DONE: st_d = ST_ACCUM;
      default: st_d = ST_ACCUM;
    endcase
    mean_d = mean_ld ? mean_new : mean_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q    <= '0;
      p2_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      st_q    <= ST_ACCUM;
      drain_q <= 1'b0;
      vs_q    <= ~VS_POL;
      mean_q  <= '0;
    end else begin
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      drain_q <= drain_d;
      vs_q    <= vs_d;
      mean_q  <= mean_d;
    end
  end

  luma_div #(.SUM_W(SUM_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .dvd_i   (sum_nxt),
    .dvs_i   ({8'h00, cnt_nxt}),
    .done_o  (div_done),
    .quo_o   (div_quo)
  );

`ifdef BRIGHT_STAT_AUTO_EN
  step_t step_q, step_d;

  always_comb begin
    step_d = mean_ld ? step_of_mean(mean_new) : step_q;
  end

  always_ff @(posedge clk) begin
    if (rst) step_q <= STEP_HOLD;
    else     step_q <= step_d;
  end

  assign step_o = step_q;
`else
  assign step_o = STEP_HOLD;
`endif

  assign mean_o       = mean_q;
  assign mean_valid_o = (st_q == ST_DONE);
  assign busy_o       = (st_q != ST_ACCUM);

endmodule

// File: doc/bright_stat.md
BRIGHT_STAT -- requirements
Module: bright_stat

Interface
REQ-001 The block SHALL have a parameter CNT_W, default 20, giving the width of the qualified-pixel counter.
REQ-002 The block SHALL have a parameter VS_POL, default 1, giving the vs_in level that marks vertical sync.
REQ-003 The block SHALL derive a local constant SUM_W = CNT_W+8 for the luma accumulator width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port rgb_data_i, input, 16 bits: RGB565 pixel.
REQ-007 The block SHALL have port data_en_i, input, 1 bit: pixel data valid.
REQ-008 The block SHALL have port vs_in, input, 1 bit: vertical sync.
REQ-009 The block SHALL have port de_in, input, 1 bit: active-video enable.
REQ-010 The block SHALL have port mean_o, output, 8 bits: mean luma of the last completed frame.
REQ-011 The block SHALL have port mean_valid_o, output, 1 bit: one-cycle pulse when mean_o updates.
REQ-012 The block SHALL have port busy_o, output, 1 bit: high while in DRAIN, DIV or DONE.
REQ-013 The block SHALL have port step_o, output, 3 bits: suggested brightness step code.

Function
REQ-014 Each input pixel SHALL expand to 8-bit channels by zero-filling low bits: R={r5,000}, G={g6,00}, B={b5,000}.
REQ-015 Luma SHALL be Y=(77R+150G+29B)>>8, truncated, computed in a 2-stage pipeline.
REQ-016 A pixel SHALL qualify only when de_in and data_en_i are both high in the same cycle.
REQ-017 Each qualified pixel SHALL add Y to the accumulator and 1 to the counter.
REQ-018 Accumulator and counter SHALL saturate at all-ones and never wrap.
REQ-019 A frame-end event E SHALL be the first cycle vs_in is sampled equal to VS_POL after having been !VS_POL.
REQ-020 The FSM SHALL have states ACCUM, DRAIN, DIV and DONE, and SHALL reset to ACCUM.
REQ-021 On E, the FSM SHALL move ACCUM->DRAIN and hold DRAIN for 2 cycles so that pixels in the pipeline count toward the ending frame.
REQ-022 On the last DRAIN cycle, the block SHALL snapshot the sum and count into the divider and clear the accumulator and counter in the same cycle.
REQ-023 Accumulation of the next frame SHALL continue during DIV and DONE.
REQ-024 DIV SHALL be a restoring divide of 1 bit per cycle lasting exactly SUM_W cycles.
REQ-025 The quotient SHALL saturate to 255.
REQ-026 DONE SHALL last 1 cycle, during which mean_o is updated and mean_valid_o is high; the FSM SHALL then return to ACCUM.
REQ-027 mean_valid_o SHALL be high at cycle E+3+SUM_W.
REQ-028 A snapshot count of 0 SHALL yield mean_o=0, and mean_valid_o SHALL still pulse.
REQ-029 A frame-end event that occurs while not in ACCUM SHALL be ignored, and its pixels SHALL merge into the next frame.
REQ-030 mean_o SHALL hold its value between DONE states.

Reset
REQ-031 rst SHALL force, in the same edge: FSM to ACCUM, accumulator, counter and divider to 0, mean_o=0, mean_valid_o=0, busy_o=0, step_o=0, vs history=!VS_POL.
REQ-032 A reset asserted during DRAIN or DIV SHALL abort the divide with no mean_valid_o pulse.

Configuration
REQ-033 Macro BRIGHT_STAT_AUTO_EN, when defined, SHALL register step_o at DONE from the new mean using this mapping:
- <80 -> 7
- 80-99 -> 6
- 100-119 -> 5
- 120-139 -> 0
- 140-159 -> 1
- 160-179 -> 2
- 180-199 -> 3
- >=200 -> 4
REQ-034 When BRIGHT_STAT_AUTO_EN is undefined, step_o SHALL be constant 0 and the port SHALL remain present.

Structure
REQ-035 Shared package bright_pkg SHALL hold:
- luma coefficients 77/150/29;
- FSM state encoding;
- step codes 0-7, shared with the brightness adjust block;
- REQ-033 thresholds.
REQ-036 The divider SHALL be a sub-module, luma_div, with a start/done handshake, parameterised by SUM_W.

Verification
REQ-037 The bench SHALL cover: 16 qualified pixels of 0xFFFF then E -> mean_o=250, one pulse at E+3+SUM_W, step_o=4 (macro on).
REQ-038 The bench SHALL cover: 16 pixels of 0x0000 then E -> mean_o=0, step_o=7 (macro on), step_o=0 (macro off).
REQ-039 The bench SHALL cover: 8 pixels of 0xFFFF and 8 of 0x0000 -> mean_o=125, step_o=0.
REQ-040 The bench SHALL cover: de_in high with data_en_i low for all pixels, then E -> mean_o=0, pulse present.
REQ-041 The bench SHALL cover: rst asserted mid-DIV -> no pulse, mean_o=0, busy_o=0 next cycle, the next frame is measured correctly.
REQ-042 The bench SHALL cover: a second E during DIV -> ignored; the next report averages the pixels of both frames.
